bus_sram_target: RTL and testbench
==================================

# bus_sram_target

Bus responder (target) for the shared transaction bus. It answers single and burst read/write transactions issued by bus initiators such as the JTAG DMA engine. It decodes a fixed address window and backs it with an internal word-addressed SRAM. It drives its bus outputs only while it owns a transaction; all other times they are zero, so they can be OR-combined on the bus.

## Interface
- Base, 32'h40000000, byte address of word 0 of the window (4-byte aligned).
- AddrWidth, 9, log2 of SRAM depth in 32-bit words; window size is 4·2^AddrWidth bytes.
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- address_dataIN  in  32  address during begin cycle, write data during data cycles.
- begin_transactionIN  in  1  initiator starts a transaction this cycle.
- end_transactionIN  in  1  initiator ends or aborts the transaction.
- read_n_writeIN  in  1  1 = read, 0 = write; sampled with begin.
- byte_enableIN  in  4  byte lanes; sampled with begin and applied to every write word.
- burst_sizeIN  in  8  number of words minus 1; sampled with begin.
- data_validIN  in  1  write word valid on address_dataIN.
- busyIN  in  1  initiator stalls read data.
- address_dataOUT  out  32  read data.
- data_validOUT  out  1  read word valid.
- end_transactionOUT  out  1  target completed the read burst.
- busyOUT  out  1  target stall; always 0 in this version.
- errorOUT  out  1  one-cycle error pulse.

## Operation
- States: IDLE, WRITE, READ_WAIT, READ_DATA, READ_END, ERROR.
- IDLE: on begin_transactionIN, latch the word index ((address − Base) >> 2), read_n_writeIN, byte_enableIN, and remaining count = burst_sizeIN.
  - Hit: Base ≤ address < Base + 4·2^AddrWidth, and index + burst_sizeIN < 2^AddrWidth (no wrap past the window end).
    - Hit and read goes to READ_WAIT; hit and write goes to WRITE.
  - Address below the window or at/after its end: ignored, stay IDLE, no response.
  - Address in the window but burst crosses the window end: go to ERROR.
- WRITE:
  - Each cycle with data_validIN=1, write address_dataIN to SRAM[index] under the latched byte enables (disabled lanes keep their old bytes), then index+1 and count−1.
  - A data_validIN when count already reached 0 (more than burst_size+1 words): go to ERROR and drop the word.
  - end_transactionIN returns to IDLE; a data_validIN in that same cycle is still written.
- READ_WAIT: one cycle of SRAM access for the word at index, then READ_DATA.
- READ_DATA:
  - Drive data_validOUT=1 and address_dataOUT=SRAM word.
  - Word is accepted when busyIN=0. If busyIN=1, hold the same word.
  - On acceptance: if count=0 go to READ_END, else index+1, count−1, and the next word is presented the following cycle (the SRAM read address is prefetched as index+1).
- READ_END: end_transactionOUT=1 for one cycle, then IDLE.
- ERROR: errorOUT=1 for one cycle, then IDLE; latched fields are cleared.
- end_transactionIN in any non-IDLE state aborts to IDLE next cycle; a pending read word is discarded; no errorOUT.
- begin_transactionIN while not IDLE is ignored.
- Reads return all 32 bits regardless of byte enables.
- Index arithmetic is AddrWidth bits; the range check guarantees no wrap.

## Timing
- Reset (async, reset=0): state IDLE; all outputs 0; latched index/count/flags 0. SRAM contents are not cleared.
- Outputs are 0 in IDLE, WRITE, and READ_WAIT, except errorOUT in ERROR.
- Read: begin at cycle T → first data_validOUT at T+2. Back-to-back words every cycle while busyIN=0. end_transactionOUT one cycle after the last accepted word.
- Write: zero wait states. A word presented at cycle T is readable from a transaction starting at T+1.
- Error: errorOUT asserted exactly one cycle after the offending begin or data cycle.
- Reset asserted mid-burst: immediate return to IDLE, outputs 0; SRAM words already written persist.

## Test plan
- Single write then read: write 32'hDEADBEEF to 0x40000010 with byte_enable 4'hF, burst 0; then read it → data_validOUT at T+2 with 32'hDEADBEEF, end_transactionOUT at T+3.
- Byte-lane write: preload 0x11223344, write 0xAABBCCDD with byte_enable 4'b0101 → readback 0x11BB33DD.
- Burst read of 4 words from 0x40000000 with busyIN high on the 2nd word for 3 cycles → words 0..3 in order, word 1 held 4 cycles, single end_transactionOUT after word 3.
- Boundary: burst_size 1 at the last word index (0x400007FC) → errorOUT one cycle after begin, no data. Same access with burst_size 0 succeeds.
- Miss and overrun: begin at 0x50000000 → all outputs remain 0. Write burst_size 0 followed by 2 data_validIN words → first word written, errorOUT pulsed, second word dropped.
- Abort/reset: end_transactionIN during READ_DATA → outputs 0 next cycle, IDLE. reset low mid-write burst → outputs 0 immediately and the next transaction works.

Source files
------------

// File: rtl/bus_sram_target.sv
// Bus target backing a fixed address window with a word-addressed SRAM.
// Outputs are zero unless this target owns a transaction so they can be OR-combined.
module bus_sram_target #(
    parameter logic [31:0] Base      = 32'h40000000,
    parameter int unsigned AddrWidth = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dataIN,
    input  logic        begin_transactionIN,
    input  logic        end_transactionIN,
    input  logic        read_n_writeIN,
    input  logic [3:0]  byte_enableIN,
    input  logic [7:0]  burst_sizeIN,
    input  logic        data_validIN,
    input  logic        busyIN,
    output logic [31:0] address_dataOUT,
    output logic        data_validOUT,
    output logic        end_transactionOUT,
    output logic        busyOUT,
    output logic        errorOUT
);

    localparam int unsigned Depth    = 1 << AddrWidth;
    localparam logic [31:0] WinBytes = 32'(Depth) << 2;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StReadWait,
        StReadData,
        StReadEnd,
        StError
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] index_q, index_d;
    logic [7:0]           count_q, count_d;
    logic                 rnw_q, rnw_d;
    logic [3:0]           be_q, be_d;
    logic                 done_q, done_d;

    logic [31:0] mem [Depth];
    logic [31:0] rdata_q;

    logic [31:0] offset;
    logic        in_window;
    logic        fits;
    logic        mem_we;

    assign offset    = address_dataIN - Base;
    assign in_window = (address_dataIN >= Base) && (offset < WinBytes);
    assign fits      = (32'(offset[31:2]) + 32'(burst_sizeIN)) < 32'(Depth);

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        count_d = count_q;
        rnw_d   = rnw_q;
        be_d    = be_q;
        done_d  = done_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (begin_transactionIN && in_window) begin
                    index_d = offset[AddrWidth+1:2];
                    count_d = burst_sizeIN;
                    rnw_d   = read_n_writeIN;
                    be_d    = byte_enableIN;
                    done_d  = 1'b0;
                    if (!fits) begin
                        state_d = StError;
                    end else if (read_n_writeIN) begin
                        state_d = StReadWait;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                // done_q marks that all burst_size+1 words have arrived; one more is an overrun
                if (data_validIN) begin
                    if (done_q) begin
                        state_d = StError;
                    end else begin
                        mem_we = !rnw_q;
                        if (count_q == 8'd0) begin
                            done_d = 1'b1;
                        end else begin
                            index_d = index_q + AddrWidth'(1);
                            count_d = count_q - 8'd1;
                        end
                    end
                end
            end
            StReadWait: state_d = StReadData;
            StReadData: begin
                if (!busyIN) begin
                    if (count_q == 8'd0) begin
                        state_d = StReadEnd;
                    end else begin
                        index_d = index_q + AddrWidth'(1);
                        count_d = count_q - 8'd1;
                    end
                end
            end
            StReadEnd: state_d = StIdle;
            StError: begin
                state_d = StIdle;
                index_d = '0;
                count_d = '0;
                rnw_d   = 1'b0;
                be_d    = '0;
                done_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
        // An initiator abort wins over every other transition
        if (end_transactionIN && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            index_q <= '0;
            count_q <= '0;
            rnw_q   <= 1'b0;
            be_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            count_q <= count_d;
            rnw_q   <= rnw_d;
            be_q    <= be_d;
            done_q  <= done_d;
        end
    end

    // Reading at index_d prefetches the next word so accepted words stream every cycle
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[index_q][8*b +: 8] <= address_dataIN[8*b +: 8];
                end
            end
        end
        rdata_q <= mem[index_d];
    end

    assign data_validOUT      = (state_q == StReadData);
    assign address_dataOUT    = data_validOUT ? rdata_q : '0;
    assign end_transactionOUT = (state_q == StReadEnd);
    assign errorOUT           = (state_q == StError);
    assign busyOUT            = 1'b0;

endmodule

// File: tb/tb_bus_sram_target.sv
// Bench for bus_sram_target: directed vector table, hand-written corner sequences,
// and randomized bursts checked against an array model of the SRAM window.
module tb_bus_sram_target;

    localparam logic [31:0] Base  = 32'h40000000;
    localparam int          Depth = 512;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_dataIN = '0;
    logic        begin_transactionIN = 1'b0;
    logic        end_transactionIN = 1'b0;
    logic        read_n_writeIN = 1'b0;
    logic [3:0]  byte_enableIN = '0;
    logic [7:0]  burst_sizeIN = '0;
    logic        data_validIN = 1'b0;
    logic        busyIN = 1'b0;
    logic [31:0] address_dataOUT;
    logic        data_validOUT;
    logic        end_transactionOUT;
    logic        busyOUT;
    logic        errorOUT;

    bus_sram_target #(
        .Base      (Base),
        .AddrWidth (9)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .address_dataIN      (address_dataIN),
        .begin_transactionIN (begin_transactionIN),
        .end_transactionIN   (end_transactionIN),
        .read_n_writeIN      (read_n_writeIN),
        .byte_enableIN       (byte_enableIN),
        .burst_sizeIN        (burst_sizeIN),
        .data_validIN        (data_validIN),
        .busyIN              (busyIN),
        .address_dataOUT     (address_dataOUT),
        .data_validOUT       (data_validOUT),
        .end_transactionOUT  (end_transactionOUT),
        .busyOUT             (busyOUT),
        .errorOUT            (errorOUT)
    );

    always #5 clock = ~clock;

    typedef enum int {KHit, KMiss, KErr} kind_e;
    typedef struct {
        logic [31:0] addr;
        logic        rnw;
        logic [3:0]  be;
        logic [7:0]  burst;
        logic [31:0] data;  // write data, or expected read data
        kind_e       kind;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl [Depth];

    function automatic logic [35:0] outs();
        return {address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT};
    endfunction

    function automatic logic [35:0] ex(input logic [31:0] d, input logic dv, input logic et,
                                       input logic er);
        return {d, dv, et, 1'b0, er};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic check_now(input string name, input logic [35:0] exp);
        n_vec++;
        if (outs() !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, outs(), exp);
        end
    endtask

    task automatic check(input string name, input logic [35:0] exp);
        @(negedge clock);
        check_now(name, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        begin_transactionIN = 1'b0;
        end_transactionIN   = 1'b0;
        read_n_writeIN      = 1'b0;
        byte_enableIN       = '0;
        burst_sizeIN        = '0;
        data_validIN        = 1'b0;
        busyIN              = 1'b0;
        address_dataIN      = '0;
    endtask

    task automatic begin_op(input logic [31:0] a, input logic rnw, input logic [3:0] be,
                            input logic [7:0] bs);
        idle();
        begin_transactionIN = 1'b1;
        address_dataIN      = a;
        read_n_writeIN      = rnw;
        byte_enableIN       = be;
        burst_sizeIN        = bs;
    endtask

    task automatic wr_burst(input int idx, input logic [3:0] be, input int n, input bit gaps);
        logic [31:0] w;
        begin_op(Base + 32'(idx * 4), 1'b0, be, 8'(n - 1));
        check("wr_begin", '0);
        step();
        idle();
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                for (int g = 0; g < 2 && ($urandom % 4) == 0; g++) begin
                    check("wr_gap", '0);
                    step();
                end
            end
            w                 = $urandom;
            address_dataIN    = w;
            data_validIN      = 1'b1;
            end_transactionIN = (k == n - 1);
            mdl[idx + k]      = merge(mdl[idx + k], w, be);
            check("wr_data", '0);
            step();
            idle();
        end
        check("wr_done", '0);
        step();
    endtask

    task automatic rd_burst(input int idx, input int n, input bit rand_busy,
                            input logic [31:0] busy_bits);
        int k   = 0;
        int cyc = 0;
        begin_op(Base + 32'(idx * 4), 1'b1, 4'($urandom), 8'(n - 1));
        check("rd_begin", '0);
        step();
        idle();
        check("rd_wait", '0);
        step();
        while (k < n && cyc < 200) begin
            busyIN = rand_busy ? (($urandom % 3) == 0) : ((cyc < 32) ? busy_bits[cyc] : 1'b0);
            check("rd_data", ex(mdl[idx + k], 1'b1, 1'b0, 1'b0));
            step();
            if (!busyIN) k++;
            cyc++;
        end
        if (k < n) begin
            n_vec++;
            n_err++;
            $display("FAIL rd_timeout: accepted %0d words, want %0d", k, n);
        end
        busyIN = 1'b0;
        check("rd_end", ex('0, 1'b0, 1'b1, 1'b0));
        step();
        check("rd_idle", '0);
        step();
    endtask

    task automatic err_op(input logic [31:0] a, input logic rnw, input logic [7:0] bs);
        begin_op(a, rnw, 4'hF, bs);
        check("err_begin", '0);
        step();
        idle();
        check("err_pulse", ex('0, 1'b0, 1'b0, 1'b1));
        step();
        check("err_after", '0);
        step();
    endtask

    task automatic miss_op(input logic [31:0] a, input logic rnw);
        begin_op(a, rnw, 4'hF, 8'($urandom % 4));
        check("miss_begin", '0);
        step();
        idle();
        check("miss_t1", '0);
        step();
        check("miss_t2", '0);
        step();
    endtask

    task automatic run_vec(input vec_t v);
        int idx = int'((v.addr - Base) >> 2);
        if (v.kind == KErr) begin
            err_op(v.addr, v.rnw, v.burst);
        end else if (v.kind == KMiss) begin
            miss_op(v.addr, v.rnw);
        end else if (!v.rnw) begin
            begin_op(v.addr, 1'b0, v.be, v.burst);
            check("vec_wr_begin", '0);
            step();
            idle();
            data_validIN      = 1'b1;
            end_transactionIN = 1'b1;
            address_dataIN    = v.data;
            mdl[idx]          = merge(mdl[idx], v.data, v.be);
            check("vec_wr_data", '0);
            step();
            idle();
            check("vec_wr_done", '0);
            step();
        end else begin
            begin_op(v.addr, 1'b1, v.be, v.burst);
            check("vec_rd_begin", '0);
            step();
            idle();
            check("vec_rd_wait", '0);
            step();
            check("vec_rd_data", ex(v.data, 1'b1, 1'b0, 1'b0));
            step();
            check("vec_rd_end", ex('0, 1'b0, 1'b1, 1'b0));
            step();
            check("vec_rd_idle", '0);
            step();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [12];
        logic [31:0] w1;
        logic [31:0] w2;
        int          idx;
        int          bs;

        vecs[0]  = '{32'h40000010, 1'b0, 4'hF, 8'd0, 32'hDEADBEEF, KHit};
        vecs[1]  = '{32'h40000010, 1'b1, 4'hF, 8'd0, 32'hDEADBEEF, KHit};
        vecs[2]  = '{32'h40000020, 1'b0, 4'hF, 8'd0, 32'h11223344, KHit};
        vecs[3]  = '{32'h40000020, 1'b0, 4'b0101, 8'd0, 32'hAABBCCDD, KHit};
        vecs[4]  = '{32'h40000020, 1'b1, 4'h0, 8'd0, 32'h11BB33DD, KHit};
        vecs[5]  = '{32'h400007FC, 1'b1, 4'hF, 8'd1, 32'h0, KErr};
        vecs[6]  = '{32'h400007FC, 1'b0, 4'hF, 8'd0, 32'hCAFEF00D, KHit};
        vecs[7]  = '{32'h400007FC, 1'b1, 4'hF, 8'd0, 32'hCAFEF00D, KHit};
        vecs[8]  = '{32'h50000000, 1'b1, 4'hF, 8'd0, 32'h0, KMiss};
        vecs[9]  = '{32'h3FFFFFFC, 1'b0, 4'hF, 8'd0, 32'h0, KMiss};
        vecs[10] = '{32'h40000800, 1'b1, 4'hF, 8'd0, 32'h0, KMiss};
        vecs[11] = '{32'h400007F8, 1'b0, 4'hF, 8'd2, 32'h0, KErr};

        idle();
        #3;
        check_now("reset_outs", '0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        check("post_reset", '0);
        step();

        // Give every SRAM word a known value
        wr_burst(0, 4'hF, 256, 1'b0);
        wr_burst(256, 4'hF, 256, 1'b0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Burst of 4 with word 1 stalled for three cycles
        wr_burst(0, 4'hF, 4, 1'b0);
        rd_burst(0, 4, 1'b0, 32'b01110);

        // Overrun: burst_size 0 but two data words
        w1 = $urandom;
        w2 = $urandom;
        begin_op(Base + 32'h100, 1'b0, 4'hF, 8'd0);
        check("ovr_begin", '0);
        step();
        idle();
        data_validIN   = 1'b1;
        address_dataIN = w1;
        mdl[32'h40]    = w1;
        check("ovr_w1", '0);
        step();
        address_dataIN = w2;
        check("ovr_w2", '0);
        step();
        idle();
        check("ovr_err", ex('0, 1'b0, 1'b0, 1'b1));
        step();
        check("ovr_idle", '0);
        step();
        rd_burst(32'h40, 2, 1'b0, '0);

        // Abort during read data
        begin_op(Base + 32'h40, 1'b1, 4'hF, 8'd3);
        step();
        idle();
        step();
        end_transactionIN = 1'b1;
        check("abort_data", ex(mdl[16], 1'b1, 1'b0, 1'b0));
        step();
        idle();
        check("abort_idle", '0);
        step();
        check("abort_idle2", '0);
        step();

        // Reset in the middle of a write burst; written words persist
        begin_op(Base + 32'h200, 1'b0, 4'hF, 8'd7);
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            w1                = $urandom;
            data_validIN      = 1'b1;
            address_dataIN    = w1;
            mdl[32'h80 + k]   = w1;
            step();
        end
        idle();
        #1;
        reset = 1'b0;
        #1;
        check_now("rst_wr_outs", '0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        rd_burst(32'h80, 3, 1'b1, '0);

        // Reset while a read word is on the bus clears outputs immediately
        begin_op(Base + 32'h200, 1'b1, 4'hF, 8'd2);
        step();
        idle();
        step();
        #1;
        check_now("rst_rd_pre", ex(mdl[32'h80], 1'b1, 1'b0, 1'b0));
        reset = 1'b0;
        #1;
        check_now("rst_rd_outs", '0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 200; i++) begin
            if (($urandom % 10) == 0) begin
                if ($urandom % 2) miss_op(Base + 32'h800 + 32'(($urandom % 64) * 4), 1'($urandom));
                else              miss_op(Base - 32'h4 - 32'(($urandom % 64) * 4), 1'($urandom));
            end else begin
                idx = (($urandom % 4) == 0) ? 505 + int'($urandom % 7) : int'($urandom % Depth);
                bs  = int'($urandom % 8);
                if (idx + bs > Depth - 1) begin
                    err_op(Base + 32'(idx * 4), 1'($urandom), 8'(bs));
                end else if ($urandom % 2) begin
                    rd_burst(idx, bs + 1, 1'b1, '0);
                end else begin
                    wr_burst(idx, 4'($urandom), bs + 1, 1'b1);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
